// File: rtl/imm_gen_pkg.sv
// Shared types for the decode-stage immediate generator: format codes, opcodes,
// the {imm, sel, illegal} result bundle and the opcode-driven format decoder.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_I     = 3'd0,
    FMT_S     = 3'd1,
    FMT_B     = 3'd2,
    FMT_J     = 3'd3,
    FMT_U     = 3'd4,
    FMT_Z     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ILL   = 3'd7
  } imm_fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } skid_state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // imm is carried at the widest legal XLEN; narrower builds use the low bits.
  typedef struct packed {
    logic [63:0] imm;
    imm_fmt_e    sel;
    logic        illegal;
  } imm_res_t;

  function automatic imm_fmt_e decode_fmt(input logic [6:0] opcode, input logic [2:0] funct3);
    imm_fmt_e fmt;
    case (opcode)
      OPC_LOAD, OPC_JALR: fmt = FMT_I;
      OPC_OPIMM:          fmt = (funct3[1:0] == 2'b01) ? FMT_SHAMT : FMT_I;
      OPC_STORE:          fmt = FMT_S;
      OPC_BRANCH:         fmt = FMT_B;
      OPC_JAL:            fmt = FMT_J;
      OPC_LUI, OPC_AUIPC: fmt = FMT_U;
      OPC_SYSTEM:         fmt = funct3[2] ? FMT_Z : FMT_I;
      default:            fmt = FMT_ILL;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/imm_gen_comb.sv
// Combinational immediate extraction at XLEN width, with the format either taken
// from imm_sel or decoded from the opcode when AUTO_SEL is nonzero.
module imm_gen_comb
  import imm_gen_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int AUTO_SEL = 0
) (
  input  logic [31:0] inst,
  input  logic [2:0]  imm_sel,
  output imm_res_t    res
);

  imm_fmt_e        fmt;
  logic [5:0]      shamt;
  logic [XLEN-1:0] imm;

  assign fmt   = (AUTO_SEL != 0) ? decode_fmt(inst[6:0], inst[14:12]) : imm_fmt_e'(imm_sel);
  // RV64 shifts use a 6-bit amount; RV32 keeps bit 25 out of it.
  assign shamt = (XLEN == 64) ? inst[25:20] : {1'b0, inst[24:20]};

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:     imm = {{(XLEN-11){inst[31]}}, inst[30:20]};
      FMT_S:     imm = {{(XLEN-11){inst[31]}}, inst[30:25], inst[11:7]};
      FMT_B:     imm = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_J:     imm = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      FMT_U:     imm = {{(XLEN-31){inst[31]}}, inst[30:12], 12'h000};
      FMT_Z:     imm = {{(XLEN-5){1'b0}}, inst[19:15]};
      FMT_SHAMT: imm = {{(XLEN-6){1'b0}}, shamt};
      default:   imm = '0;
    endcase
  end

  always_comb begin
    res         = '0;
    res.imm     = 64'($signed(imm));
    res.sel     = fmt;
    res.illegal = (fmt == FMT_ILL);
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready handshake and a two-entry skid.
// Optional counters stat_accepted/stat_illegal are built when IMM_GEN_STATS_EN is defined.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int AUTO_SEL = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [2:0]      in_imm_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_sel,
  output logic            out_illegal
`ifdef IMM_GEN_STATS_EN
  ,
  output logic [31:0]     stat_accepted,
  output logic [15:0]     stat_illegal
`endif
);

  imm_res_t    comb_res;
  imm_res_t    main_reg;
  imm_res_t    skid_reg;
  skid_state_e state_reg;
  logic        accept;
  logic        drain;

  imm_gen_comb #(
    .XLEN     (XLEN),
    .AUTO_SEL (AUTO_SEL)
  ) u_comb (
    .inst    (in_inst),
    .imm_sel (in_imm_sel),
    .res     (comb_res)
  );

  // Both handshake outputs decode straight from the state register, so out_ready
  // never reaches in_ready combinationally.
  assign in_ready  = (state_reg != ST_FULL);
  assign out_valid = (state_reg != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
    end else if (flush) begin
      state_reg <= ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            main_reg  <= comb_res;
            state_reg <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_reg <= comb_res;
          end else if (accept) begin
            skid_reg  <= comb_res;
            state_reg <= ST_FULL;
          end else if (drain) begin
            state_reg <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            main_reg  <= skid_reg;
            state_reg <= ST_ONE;
          end
        end
        default: state_reg <= ST_EMPTY;
      endcase
    end
  end

  assign out_imm     = main_reg.imm[XLEN-1:0];
  assign out_sel     = main_reg.sel;
  assign out_illegal = main_reg.illegal;

  generate
    if (XLEN < 64) begin : g_narrow
      logic unused_hi;
      assign unused_hi = ^main_reg.imm[63:XLEN];
    end
  endgenerate

`ifdef IMM_GEN_STATS_EN
  logic [31:0] accepted_cnt_reg;
  logic [15:0] illegal_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accepted_cnt_reg <= '0;
      illegal_cnt_reg  <= '0;
    end else if (accept && !flush) begin
      accepted_cnt_reg <= accepted_cnt_reg + 32'd1;
      if (comb_res.illegal && (illegal_cnt_reg != 16'hFFFF))
        illegal_cnt_reg <= illegal_cnt_reg + 16'd1;
    end
  end

  assign stat_accepted = accepted_cnt_reg;
  assign stat_illegal  = illegal_cnt_reg;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: an XLEN=32 manual-select instance and an
// XLEN=64 AUTO_SEL instance, each with its own expected-value queue and monitor.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        m_flush, m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_out_illegal;
  logic [31:0] m_in_inst, m_out_imm;
  logic [2:0]  m_in_sel, m_out_sel;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
  logic [31:0] a_in_inst;
  logic [63:0] a_out_imm;
  logic [2:0]  a_in_sel, a_out_sel;

`ifdef IMM_GEN_STATS_EN
  logic [31:0] m_stat_acc, a_stat_acc;
  logic [15:0] m_stat_ill, a_stat_ill;
`endif

  imm_gen_pipe #(.XLEN(32), .AUTO_SEL(0)) u_man (
    .clk(clk), .rst_n(rst_n), .flush(m_flush),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .in_inst(m_in_inst), .in_imm_sel(m_in_sel),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .out_imm(m_out_imm),
    .out_sel(m_out_sel), .out_illegal(m_out_illegal)
`ifdef IMM_GEN_STATS_EN
    , .stat_accepted(m_stat_acc), .stat_illegal(m_stat_ill)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .AUTO_SEL(1)) u_auto (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inst(a_in_inst), .in_imm_sel(a_in_sel),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm),
    .out_sel(a_out_sel), .out_illegal(a_out_illegal)
`ifdef IMM_GEN_STATS_EN
    , .stat_accepted(a_stat_acc), .stat_illegal(a_stat_ill)
`endif
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  sel;
    logic        ill;
  } exp_t;

  exp_t m_q[$];
  exp_t a_q[$];
  int errors = 0;
  int checks = 0;
  int m_acc_cnt = 0, m_ill_cnt = 0, a_acc_cnt = 0, a_ill_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Manual-instance monitor: scoreboard pop on every transfer, plus stall stability.
  initial begin
    exp_t        e;
    logic        stalled;
    logic [31:0] held_imm;
    logic [2:0]  held_sel;
    stalled = 1'b0;
    held_imm = '0;
    held_sel = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled && m_out_valid) begin
          check("man_stable_imm", {32'h0, m_out_imm}, {32'h0, held_imm});
          check("man_stable_sel", {61'h0, m_out_sel}, {61'h0, held_sel});
        end
        if (m_out_valid && m_out_ready) begin
          if (m_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL man_unexpected_output: got imm 0x%0h, expected no output", m_out_imm);
          end else begin
            e = m_q.pop_front();
            $display("man out imm=0x%08h sel=%0d ill=%0b", m_out_imm, m_out_sel, m_out_illegal);
            check("man_imm", {32'h0, m_out_imm}, {32'h0, e.imm[31:0]});
            check("man_sel", {61'h0, m_out_sel}, {61'h0, e.sel});
            check("man_ill", {63'h0, m_out_illegal}, {63'h0, e.ill});
          end
        end
        stalled  = m_out_valid && !m_out_ready;
        held_imm = m_out_imm;
        held_sel = m_out_sel;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && a_out_valid && a_out_ready) begin
        if (a_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL auto_unexpected_output: got imm 0x%0h, expected no output", a_out_imm);
        end else begin
          e = a_q.pop_front();
          $display("auto out imm=0x%016h sel=%0d ill=%0b", a_out_imm, a_out_sel, a_out_illegal);
          check("auto_imm", a_out_imm, e.imm);
          check("auto_sel", {61'h0, a_out_sel}, {61'h0, e.sel});
          check("auto_ill", {63'h0, a_out_illegal}, {63'h0, e.ill});
        end
      end
    end
  end

  task automatic send_m(input logic [31:0] inst, input logic [2:0] sel,
                        input logic [63:0] eimm, input logic [2:0] esel, input logic eill);
    int n = 0;
    m_in_inst  = inst;
    m_in_sel   = sel;
    m_in_valid = 1'b1;
    @(negedge clk);
    while (!m_in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!m_in_ready) begin
      checks++;
      errors++;
      $display("FAIL man_accept_timeout: in_ready=0 after 20 cycles, expected 1");
    end else begin
      m_q.push_back('{eimm, esel, eill});
      m_acc_cnt++;
      if (eill) m_ill_cnt++;
    end
    @(posedge clk);
    #1;
    m_in_valid = 1'b0;
  endtask

  task automatic send_a(input logic [31:0] inst, input logic [63:0] eimm,
                        input logic [2:0] esel, input logic eill);
    int n = 0;
    a_in_inst  = inst;
    a_in_sel   = 3'b111;
    a_in_valid = 1'b1;
    @(negedge clk);
    while (!a_in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!a_in_ready) begin
      checks++;
      errors++;
      $display("FAIL auto_accept_timeout: in_ready=0 after 20 cycles, expected 1");
    end else begin
      a_q.push_back('{eimm, esel, eill});
      a_acc_cnt++;
      if (eill) a_ill_cnt++;
    end
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while ((m_q.size() != 0 || a_q.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (m_q.size() != 0 || a_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending man=%0d auto=%0d, expected 0", m_q.size(), a_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  logic [31:0] mv_inst [8] = '{32'hFE000EE3, 32'h123450B7, 32'h00112423, 32'hFF9FF06F,
                               32'h000FD073, 32'h03F0D093, 32'h0000007F, 32'h80000013};
  logic [2:0]  mv_sel  [8] = '{3'd2, 3'd4, 3'd1, 3'd3, 3'd5, 3'd6, 3'd7, 3'd0};
  logic [63:0] mv_imm  [8] = '{64'hFFFFFFFC, 64'h12345000, 64'h8, 64'hFFFFFFF8,
                               64'h1F, 64'h1F, 64'h0, 64'hFFFFF800};

  logic [31:0] av_inst [11] = '{32'h800000B7, 32'h03F0D093, 32'h02001013, 32'h0000007F,
                                32'hFFC12083, 32'h00112423, 32'hFE000EE3, 32'hFF9FF06F,
                                32'h000FD073, 32'h00000073, 32'h00001097};
  logic [63:0] av_imm  [11] = '{64'hFFFFFFFF80000000, 64'h3F, 64'h20, 64'h0,
                                64'hFFFFFFFFFFFFFFFC, 64'h8, 64'hFFFFFFFFFFFFFFFC,
                                64'hFFFFFFFFFFFFFFF8, 64'h1F, 64'h0, 64'h1000};
  logic [2:0]  av_sel  [11] = '{3'd4, 3'd6, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd0, 3'd4};

  time t0;

  initial begin
    m_flush = 0; m_in_valid = 0; m_in_inst = 0; m_in_sel = 0; m_out_ready = 0;
    a_flush = 0; a_in_valid = 0; a_in_inst = 0; a_in_sel = 0; a_out_ready = 0;

    #12;
    check("rst_man_out_valid", {63'h0, m_out_valid}, 64'h0);
    check("rst_man_in_ready", {63'h0, m_in_ready}, 64'h1);
    check("rst_man_out_imm", {32'h0, m_out_imm}, 64'h0);
    check("rst_man_out_sel", {61'h0, m_out_sel}, 64'h0);
    check("rst_man_out_illegal", {63'h0, m_out_illegal}, 64'h0);
    check("rst_auto_out_valid", {63'h0, a_out_valid}, 64'h0);
    check("rst_auto_in_ready", {63'h0, a_in_ready}, 64'h1);
    check("rst_auto_out_imm", a_out_imm, 64'h0);
`ifdef IMM_GEN_STATS_EN
    check("rst_man_stat_acc", {32'h0, m_stat_acc}, 64'h0);
    check("rst_auto_stat_ill", {48'h0, a_stat_ill}, 64'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    m_out_ready = 1'b1;
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;

    // one-cycle latency from accept to out_valid
    send_m(32'hFFF00093, 3'd0, 64'hFFFFFFFF, 3'd0, 1'b0);
    check("man_latency_valid", {63'h0, m_out_valid}, 64'h1);

    t0 = $time;
    for (int i = 0; i < 8; i++) send_m(mv_inst[i], mv_sel[i], mv_imm[i], mv_sel[i], mv_sel[i] == 3'd7);
    check("man_throughput_cycles", 64'(($time - t0) / 10), 64'd8);
    wait_empty();

    for (int i = 0; i < 11; i++) send_a(av_inst[i], av_imm[i], av_sel[i], av_sel[i] == 3'd7);
    wait_empty();
`ifdef IMM_GEN_STATS_EN
    check("auto_stat_acc", {32'h0, a_stat_acc}, 64'(a_acc_cnt));
    check("auto_stat_ill", {48'h0, a_stat_ill}, 64'(a_ill_cnt));
`endif

    // backpressure: two accepted, third waits until the skid drains
    m_out_ready = 1'b0;
    send_m(32'h00100093, 3'd0, 64'h1, 3'd0, 1'b0);
    send_m(32'h00200093, 3'd0, 64'h2, 3'd0, 1'b0);
    fork
      send_m(32'h00300093, 3'd0, 64'h3, 3'd0, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("man_bp_in_ready_low", {63'h0, m_in_ready}, 64'h0);
        end
        @(posedge clk);
        #1;
        m_out_ready = 1'b1;
      end
    join
    wait_empty();

    // flush in FULL with an input offered
    m_out_ready = 1'b0;
    send_m(32'h00400093, 3'd0, 64'h4, 3'd0, 1'b0);
    send_m(32'h00500093, 3'd0, 64'h5, 3'd0, 1'b0);
    m_in_inst = 32'h00700093; m_in_sel = 3'd0; m_in_valid = 1'b1; m_flush = 1'b1;
    @(posedge clk);
    #1;
    m_flush = 1'b0; m_in_valid = 1'b0;
    m_q.delete();
    check("man_flush_full_out_valid", {63'h0, m_out_valid}, 64'h0);
    check("man_flush_full_in_ready", {63'h0, m_in_ready}, 64'h1);

    // flush in ONE while in_ready=1: the offered input must not be taken
    send_m(32'h00600093, 3'd0, 64'h6, 3'd0, 1'b0);
    m_in_inst = 32'h0000007F; m_in_sel = 3'd7; m_in_valid = 1'b1; m_flush = 1'b1;
    @(posedge clk);
    #1;
    m_flush = 1'b0; m_in_valid = 1'b0;
    m_q.delete();
    check("man_flush_one_out_valid", {63'h0, m_out_valid}, 64'h0);
    m_out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("man_flush_nothing_out", {63'h0, m_out_valid}, 64'h0);
`ifdef IMM_GEN_STATS_EN
    check("man_stat_acc", {32'h0, m_stat_acc}, 64'(m_acc_cnt));
    check("man_stat_ill", {48'h0, m_stat_ill}, 64'(m_ill_cnt));
`endif
    @(posedge clk);
    #1;

    // asynchronous reset mid-stream
    m_out_ready = 1'b0;
    send_m(32'h00800093, 3'd0, 64'h8, 3'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    m_q.delete();
    check("arst_man_out_valid", {63'h0, m_out_valid}, 64'h0);
    check("arst_man_in_ready", {63'h0, m_in_ready}, 64'h1);
    check("arst_man_out_imm", {32'h0, m_out_imm}, 64'h0);
    check("arst_man_out_sel", {61'h0, m_out_sel}, 64'h0);
`ifdef IMM_GEN_STATS_EN
    check("arst_man_stat_acc", {32'h0, m_stat_acc}, 64'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_out_ready = 1'b1;
    send_m(32'hFFF00093, 3'd0, 64'hFFFFFFFF, 3'd0, 1'b0);
    wait_empty();

    check("man_queue_drained", 64'(m_q.size()), 64'h0);
    check("auto_queue_drained", 64'(a_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
